// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_sequencer (+ wide_add_sequencer_cla8)
// Brief    : NBYTES-wide add/subtract built from one 8-bit CLA, one byte/cycle
// Revision : 1.0 - initial release
// ============================================================================

module wide_add_sequencer_cla8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;

  // Carry into bit msb+1, flattened from cin and the generate/propagate terms.
  function automatic logic f_lookahead(input logic [7:0] g, input logic [7:0] p,
                                       input logic cin, input int msb);
    logic c;
    logic t;
    c = cin;
    for (int j = 0; j < 8; j++)
      if (j <= msb) c = c & p[j];
    for (int j = 0; j < 8; j++) begin
      if (j <= msb) begin
        t = g[j];
        for (int k = 0; k < 8; k++)
          if (k > j && k <= msb) t = t & p[k];
        c = c | t;
      end
    end
    return c;
  endfunction

  assign w_g    = i_a & i_b;
  assign w_p    = i_a ^ i_b;
  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < 8; gi++) begin : g_carry
    assign w_c[gi+1] = f_lookahead(w_g, w_p, i_cin, gi);
  end

  assign o_sum  = w_p ^ w_c[7:0];
  assign o_cout = w_c[8];

endmodule

module wide_add_sequencer #(
  parameter  int NBYTES = 4,
  localparam int W      = 8 * NBYTES,
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_sum,
  output logic         o_carry_out,
  output logic         o_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_LAST_IDX = CW'(NBYTES - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NBYTES-1:0][7:0]  r_a_lat;
  logic [NBYTES-1:0][7:0]  r_b_eff;
  logic [NBYTES-1:0][7:0]  r_sum;
  logic [CW-1:0]           r_idx;
  logic                    r_carry;
  logic                    r_carry_out;
  logic                    r_overflow;

  logic                    w_accept;
  logic                    w_last;
  logic [7:0]              w_add_a;
  logic [7:0]              w_add_b;
  logic [7:0]              w_add_sum;
  logic                    w_add_cout;

  assign w_accept = (r_state == ST_IDLE) && i_in_valid;
  assign w_last   = (r_state == ST_RUN) && (r_idx == C_LAST_IDX);
  assign w_add_a  = r_a_lat[r_idx];
  assign w_add_b  = r_b_eff[r_idx];

  wide_add_sequencer_cla8 u_cla8 (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (r_carry),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (r_idx == C_LAST_IDX) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_lat     <= '0;
      r_b_eff     <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_accept) begin
      // Subtract is A + ~B + 1: the +1 enters as the first byte's carry-in.
      r_a_lat <= i_a;
      r_b_eff <= i_sub ? ~i_b : i_b;
      r_carry <= i_sub;
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      r_sum[r_idx] <= w_add_sum;
      r_carry      <= w_add_cout;
      if (w_last) begin
        r_idx       <= '0;
        r_carry_out <= w_add_cout;
        r_overflow  <= (r_a_lat[NBYTES-1][7] == r_b_eff[NBYTES-1][7]) &&
                       (w_add_sum[7] != r_a_lat[NBYTES-1][7]);
      end else begin
        r_idx <= r_idx + CW'(1);
      end
    end
  end

  assign o_sum       = r_sum;
  assign o_carry_out = r_carry_out;
  assign o_overflow  = r_overflow;

endmodule

`default_nettype wire
